// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the cache-line to narrow-bus memory bridge:
// line opcodes, default tag width and the bridge state encoding.
package mem_bridge_pkg;

  localparam int LG_MEM_TAG_ENTRIES = 4;

  localparam logic [3:0] MEM_LD_LINE = 4'd4;
  localparam logic [3:0] MEM_ST_LINE = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } bridge_state_t;

  // True for the opcodes that move a line over the bus.
  function automatic logic op_is_line(input logic [3:0] op);
    return (op == MEM_LD_LINE) || (op == MEM_ST_LINE);
  endfunction

endpackage

// File: rtl/mem_line_bridge.sv
// Cache-line request port to narrow pipelined memory bus bridge.
// A line request is split into BEATS bus beats; beats keep issuing while
// earlier responses are still outstanding. Responses return in order,
// one per beat, and read beats are gathered little-endian into a line.
module mem_line_bridge
  import mem_bridge_pkg::*;
#(
  parameter int CL_BITS  = 128,
  parameter int BUS_BITS = 32,
  parameter int ADDR_W   = 64,
  parameter int TAG_W    = LG_MEM_TAG_ENTRIES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_req_valid,
  input  logic [ADDR_W-1:0]   mem_req_addr,
  input  logic [CL_BITS-1:0]  mem_req_store_data,
  input  logic [TAG_W-1:0]    mem_req_tag,
  input  logic [3:0]          mem_req_opcode,
  output logic                mem_rsp_valid,
  output logic [CL_BITS-1:0]  mem_rsp_load_data,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic [ADDR_W-1:0]   bus_req_addr,
  output logic                bus_req_we,
  output logic [BUS_BITS-1:0] bus_req_wdata,
  output logic [TAG_W-1:0]    bus_req_tag,
  input  logic                bus_rsp_valid,
  input  logic [BUS_BITS-1:0] bus_rsp_rdata,
  output logic                busy,
  output logic                bus_err
);

  localparam int BEATS      = CL_BITS / BUS_BITS;
  localparam int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W      = $clog2(BEATS) + 1;
  localparam int LINE_BYTES = CL_BITS / 8;

  localparam logic [CNT_W-1:0]  BEATS_C    = CNT_W'(BEATS);
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(BUS_BITS / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK  = ~ADDR_W'(LINE_BYTES - 1);

  bridge_state_t                   state_q;
  logic [CNT_W-1:0]                issue_cnt_q;
  logic [CNT_W-1:0]                rsp_cnt_q;
  logic [ADDR_W-1:0]               line_addr_q;
  logic [BEATS-1:0][BUS_BITS-1:0]  wline_q;
  logic [BEATS-1:0][BUS_BITS-1:0]  rline_q;
  logic [BEATS-1:0][BUS_BITS-1:0]  rline_d;
  logic [TAG_W-1:0]                tag_q;
  logic [3:0]                      op_q;
  logic [CL_BITS-1:0]              load_q;
  logic                            err_q;

  logic             issue_fire;
  logic             rsp_legal;
  logic             rsp_stray;
  logic [IDX_W-1:0] issue_idx;
  logic [IDX_W-1:0] rsp_idx;

  assign issue_idx = issue_cnt_q[IDX_W-1:0];
  assign rsp_idx   = rsp_cnt_q[IDX_W-1:0];

  // Bus request side is decoded purely from registered state, so it holds
  // steady across ready stalls without any extra holding register.
  assign bus_req_valid = (state_q == XFER) && (issue_cnt_q < BEATS_C);
  assign bus_req_addr  = line_addr_q + (ADDR_W'(issue_cnt_q) * BEAT_BYTES);
  assign bus_req_we    = (state_q == XFER) && (op_q == MEM_ST_LINE);
  assign bus_req_wdata = wline_q[issue_idx];
  assign bus_req_tag   = tag_q;

  assign issue_fire = bus_req_valid && bus_req_ready;
  // A response is only legal against a beat already accepted in an earlier cycle.
  assign rsp_legal  = bus_rsp_valid && (state_q == XFER) && (rsp_cnt_q < issue_cnt_q);
  assign rsp_stray  = bus_rsp_valid && !rsp_legal;

  assign mem_rsp_valid     = (state_q == RESP);
  assign mem_rsp_load_data = load_q;
  assign busy              = (state_q != IDLE);
  assign bus_err           = err_q;

  // Merge the arriving read beat into the gather buffer.
  always_comb begin
    rline_d = rline_q;
    if (rsp_legal && (op_q == MEM_LD_LINE)) begin
      rline_d[rsp_idx] = bus_rsp_rdata;
    end
  end

  // Gather buffer: pure data, never needs a reset value.
  always_ff @(posedge clk) begin
    rline_q <= rline_d;
  end

  // Bridge FSM: accept, issue/collect beats, pulse completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      rsp_cnt_q   <= '0;
      line_addr_q <= '0;
      wline_q     <= '0;
      tag_q       <= '0;
      op_q        <= '0;
      load_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      if (rsp_stray) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (mem_req_valid) begin
            line_addr_q <= mem_req_addr & LINE_MASK;
            wline_q     <= mem_req_store_data;
            tag_q       <= mem_req_tag;
            op_q        <= mem_req_opcode;
            issue_cnt_q <= '0;
            rsp_cnt_q   <= '0;
            if (op_is_line(mem_req_opcode)) begin
              state_q <= XFER;
            end else begin
              // Unknown operation: complete at once without touching the bus.
              state_q <= RESP;
              err_q   <= 1'b1;
            end
          end
        end
        XFER: begin
          if (issue_fire) begin
            issue_cnt_q <= issue_cnt_q + CNT_W'(1);
          end
          if (rsp_legal) begin
            rsp_cnt_q <= rsp_cnt_q + CNT_W'(1);
            if ((rsp_cnt_q + CNT_W'(1)) == BEATS_C) begin
              state_q <= RESP;
              if (op_q == MEM_LD_LINE) begin
                load_q <= rline_d;
              end
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_bridge.sv
// Testbench for mem_line_bridge: a bus slave with in-order delayed
// responses, a line-level memory reference model, and scenario tasks.
module tb_mem_line_bridge;
  import mem_bridge_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_req_valid;
  logic [63:0]  mem_req_addr;
  logic [127:0] mem_req_store_data;
  logic [3:0]   mem_req_tag;
  logic [3:0]   mem_req_opcode;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_load_data;
  logic         bus_req_valid;
  logic         bus_req_ready;
  logic [63:0]  bus_req_addr;
  logic         bus_req_we;
  logic [31:0]  bus_req_wdata;
  logic [3:0]   bus_req_tag;
  logic         bus_rsp_valid;
  logic [31:0]  bus_rsp_rdata;
  logic         busy;
  logic         bus_err;

  always #5 clk = ~clk;

  mem_line_bridge dut (
    .clk                (clk),
    .reset              (reset),
    .mem_req_valid      (mem_req_valid),
    .mem_req_addr       (mem_req_addr),
    .mem_req_store_data (mem_req_store_data),
    .mem_req_tag        (mem_req_tag),
    .mem_req_opcode     (mem_req_opcode),
    .mem_rsp_valid      (mem_rsp_valid),
    .mem_rsp_load_data  (mem_rsp_load_data),
    .bus_req_valid      (bus_req_valid),
    .bus_req_ready      (bus_req_ready),
    .bus_req_addr       (bus_req_addr),
    .bus_req_we         (bus_req_we),
    .bus_req_wdata      (bus_req_wdata),
    .bus_req_tag        (bus_req_tag),
    .bus_rsp_valid      (bus_rsp_valid),
    .bus_rsp_rdata      (bus_rsp_rdata),
    .busy               (busy),
    .bus_err            (bus_err)
  );

  typedef struct {
    int          cyc;
    logic        vld;
    logic        rdy;
    logic        we;
    logic [63:0] addr;
    logic [31:0] wd;
    logic        rv;
    logic        rsv;
  } samp_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  tag;
    int          cyc;
  } beat_t;

  typedef struct {
    int          due;
    logic [63:0] addr;
    logic        we;
  } pend_t;

  samp_t slog[$];
  beat_t blog[$];
  pend_t pend[$];

  logic [31:0] dev_mem [logic [63:0]];
  logic [31:0] ref_mem [logic [63:0]];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 1;
  int rnd_lat = 0;
  int rnd_rdy = 0;
  int stall_lo = -100;
  int stall_hi = -100;
  int acc_cyc = 0;
  bit stray_now = 1'b0;
  logic [127:0] exp_load = '0;

  function automatic logic [31:0] init_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [63:0] align(input logic [63:0] a);
    return a & ~64'hF;
  endfunction

  function automatic logic [31:0] dev_rd(input logic [63:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Expected line as seen by the requester: word i lives at line base + 4*i.
  function automatic logic [127:0] ref_line(input logic [63:0] a);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = ref_rd(align(a) + 64'(4 * i));
    return l;
  endfunction

  task automatic ref_store(input logic [63:0] a, input logic [127:0] wl);
    for (int i = 0; i < 4; i++) ref_mem[align(a) + 64'(4 * i)] = wl[32*i +: 32];
  endtask

  // One clock of the bus slave and arbiter; entered and left at a negedge.
  task automatic step();
    samp_t s;
    logic  r;
    int    rel;
    int    d;
    rel = cyc - acc_cyc;
    if (rnd_rdy != 0) r = ($urandom_range(0, 3) != 0);
    else              r = !(rel >= stall_lo && rel <= stall_hi);
    bus_req_ready = r;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus_rsp_valid = 1'b1;
      if (!pend[0].we) bus_rsp_rdata = dev_rd(pend[0].addr);
      void'(pend.pop_front());
    end else if (stray_now) begin
      bus_rsp_valid = 1'b1;
      stray_now = 1'b0;
    end
    if (bus_req_valid && r) begin
      blog.push_back('{addr: bus_req_addr, we: bus_req_we, wd: bus_req_wdata,
                       tag: bus_req_tag, cyc: cyc});
      if (bus_req_we) dev_mem[bus_req_addr] = bus_req_wdata;
      d = (rnd_lat != 0) ? int'($urandom_range(1, 3)) : lat;
      pend.push_back('{due: cyc + d, addr: bus_req_addr, we: bus_req_we});
    end
    s.cyc = cyc; s.vld = bus_req_valid; s.rdy = r; s.we = bus_req_we;
    s.addr = bus_req_addr; s.wd = bus_req_wdata; s.rv = mem_rsp_valid;
    s.rsv = bus_rsp_valid;
    slog.push_back(s);
    if (mem_rsp_valid) mem_req_valid = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_req_valid = 1'b0;
    pend.delete();
    step();
    pend.delete();
    reset = 1'b0;
    exp_load = '0;
    step();
  endtask

  // Issue one arbiter request and wait (bounded) for its completion pulse.
  task automatic run_txn(input logic [3:0] op, input logic [63:0] a,
                         input logic [127:0] wl, input logic [3:0] tg,
                         output int t_acc, output int t_rsp);
    int n;
    n = 0;
    while (busy && n < 100) begin step(); n++; end
    mem_req_valid = 1'b1; mem_req_opcode = op; mem_req_addr = a;
    mem_req_store_data = wl; mem_req_tag = tg;
    t_acc = cyc; acc_cyc = cyc; t_rsp = -1;
    n = 0;
    while (t_rsp < 0 && n < 300) begin
      if (mem_rsp_valid) t_rsp = cyc;
      step();
      n++;
    end
    mem_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pend.delete();
    step(); step();
    n_cmp++;
    if ({mem_rsp_valid, bus_req_valid, bus_req_we, busy, bus_err} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 00000",
                        {mem_rsp_valid, bus_req_valid, bus_req_we, busy, bus_err});
    end
    n_cmp++;
    if (mem_rsp_load_data !== 128'h0) begin
      n_bad++; $display("FAIL reset_load got %h want 0", mem_rsp_load_data);
    end
    n_cmp++;
    if ({bus_req_addr, bus_req_wdata, bus_req_tag} !== 100'h0) begin
      n_bad++; $display("FAIL reset_bus got %h/%h/%h want 0", bus_req_addr, bus_req_wdata, bus_req_tag);
    end
    reset = 1'b0;
    exp_load = '0;
    step();
  endtask

  task automatic test_read_basic();
    int ta, tr, fv, pulses;
    for (int i = 0; i < 4; i++) begin
      dev_mem[64'h1000 + 64'(4 * i)] = 32'h11111111 * 32'(i + 1);
      ref_mem[64'h1000 + 64'(4 * i)] = 32'h11111111 * 32'(i + 1);
    end
    blog.delete(); slog.delete(); lat = 1;
    run_txn(MEM_LD_LINE, 64'h1008, '0, 4'h5, ta, tr);
    exp_load = ref_line(64'h1008);
    n_cmp++;
    if (tr - ta != 6) begin n_bad++; $display("FAIL rd_latency got %0d want 6", tr - ta); end
    n_cmp++;
    if (blog.size() != 4) begin n_bad++; $display("FAIL rd_beats got %0d want 4", blog.size()); end
    for (int i = 0; i < blog.size(); i++) begin
      n_cmp++;
      if ({blog[i].addr, blog[i].we, blog[i].tag} !== {64'h1000 + 64'(4 * i), 1'b0, 4'h5}) begin
        n_bad++; $display("FAIL rd_beat%0d got %h/%b/%h want %h/0/5", i, blog[i].addr,
                          blog[i].we, blog[i].tag, 64'h1000 + 64'(4 * i));
      end
    end
    fv = -1;
    for (int i = 0; i < slog.size(); i++) if (fv < 0 && slog[i].vld) fv = slog[i].cyc;
    n_cmp++;
    if (fv != ta + 1) begin n_bad++; $display("FAIL rd_first_valid got %0d want %0d", fv, ta + 1); end
    n_cmp++;
    if (mem_rsp_load_data !== 128'h44444444_33333333_22222222_11111111) begin
      n_bad++; $display("FAIL rd_data got %h want 44444444333333332222222211111111", mem_rsp_load_data);
    end
    step();
    pulses = 0;
    for (int i = 0; i < slog.size(); i++) if (slog[i].rv) pulses++;
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL rd_pulse_count got %0d want 1", pulses); end
  endtask

  task automatic test_write_stall();
    int ta, tr, stalls;
    logic [127:0] wl;
    wl = {$urandom, $urandom, $urandom, $urandom};
    blog.delete(); slog.delete();
    stall_lo = 2; stall_hi = 3;
    run_txn(MEM_ST_LINE, 64'h2004, wl, 4'hA, ta, tr);
    stall_lo = -100; stall_hi = -100;
    ref_store(64'h2004, wl);
    n_cmp++;
    if (tr - ta != 8) begin n_bad++; $display("FAIL wr_latency got %0d want 8", tr - ta); end
    n_cmp++;
    if (blog.size() != 4) begin n_bad++; $display("FAIL wr_beats got %0d want 4", blog.size()); end
    for (int i = 0; i < blog.size(); i++) begin
      n_cmp++;
      if ({blog[i].addr, blog[i].we, blog[i].wd} !== {64'h2000 + 64'(4 * i), 1'b1, wl[32*i +: 32]}) begin
        n_bad++; $display("FAIL wr_beat%0d got %h/%b/%h want %h/1/%h", i, blog[i].addr,
                          blog[i].we, blog[i].wd, 64'h2000 + 64'(4 * i), wl[32*i +: 32]);
      end
    end
    stalls = 0;
    for (int i = 0; i + 1 < slog.size(); i++) begin
      if (slog[i].vld && !slog[i].rdy) begin
        stalls++;
        n_cmp++;
        if ({slog[i+1].vld, slog[i+1].addr, slog[i+1].wd} !== {1'b1, slog[i].addr, slog[i].wd}) begin
          n_bad++; $display("FAIL wr_stall_stable cyc %0d got %h/%h want %h/%h", slog[i+1].cyc,
                            slog[i+1].addr, slog[i+1].wd, slog[i].addr, slog[i].wd);
        end
      end
    end
    n_cmp++;
    if (stalls != 2) begin n_bad++; $display("FAIL wr_stall_count got %0d want 2", stalls); end
    n_cmp++;
    if (mem_rsp_load_data !== exp_load) begin
      n_bad++; $display("FAIL wr_load_kept got %h want %h", mem_rsp_load_data, exp_load);
    end
  endtask

  task automatic test_delayed_rsp();
    int ta, tr, fr;
    blog.delete(); slog.delete(); lat = 4;
    run_txn(MEM_LD_LINE, 64'h2000, '0, 4'h1, ta, tr);
    lat = 1;
    exp_load = ref_line(64'h2000);
    fr = -1;
    for (int i = 0; i < slog.size(); i++) if (fr < 0 && slog[i].rsv) fr = slog[i].cyc;
    n_cmp++;
    if (tr - ta != 9) begin n_bad++; $display("FAIL dly_latency got %0d want 9", tr - ta); end
    n_cmp++;
    if (blog.size() != 4) begin
      n_bad++; $display("FAIL dly_beats got %0d want 4", blog.size());
    end else begin
      n_cmp++;
      if (blog[3].cyc >= fr) begin
        n_bad++; $display("FAIL dly_all_issued last beat cyc %0d first rsp cyc %0d", blog[3].cyc, fr);
      end
    end
    n_cmp++;
    if (mem_rsp_load_data !== exp_load) begin
      n_bad++; $display("FAIL dly_data got %h want %h", mem_rsp_load_data, exp_load);
    end
  endtask

  task automatic test_stray_and_opcode();
    int ta, tr;
    step();
    stray_now = 1'b1;
    step(); step();
    n_cmp++;
    if (bus_err !== 1'b1) begin n_bad++; $display("FAIL stray_err got %b want 1", bus_err); end
    step(); step(); step();
    n_cmp++;
    if ({bus_err, busy} !== 2'b10) begin n_bad++; $display("FAIL stray_sticky got %b want 10", {bus_err, busy}); end
    do_reset();
    n_cmp++;
    if (bus_err !== 1'b0) begin n_bad++; $display("FAIL err_cleared got %b want 0", bus_err); end
    blog.delete(); slog.delete();
    run_txn(4'd0, 64'h3000, {$urandom, $urandom, $urandom, $urandom}, 4'h3, ta, tr);
    n_cmp++;
    if (tr - ta != 1) begin n_bad++; $display("FAIL badop_latency got %0d want 1", tr - ta); end
    n_cmp++;
    if (blog.size() != 0) begin n_bad++; $display("FAIL badop_beats got %0d want 0", blog.size()); end
    n_cmp++;
    if (bus_err !== 1'b1) begin n_bad++; $display("FAIL badop_err got %b want 1", bus_err); end
    n_cmp++;
    if (mem_rsp_load_data !== exp_load) begin
      n_bad++; $display("FAIL badop_load got %h want %h", mem_rsp_load_data, exp_load);
    end
  endtask

  task automatic test_reset_mid();
    int ta, tr;
    do_reset();
    blog.delete();
    mem_req_valid = 1'b1; mem_req_opcode = MEM_LD_LINE; mem_req_addr = 64'h1000;
    mem_req_store_data = '0; mem_req_tag = 4'h6; acc_cyc = cyc;
    step(); step(); step();
    n_cmp++;
    if ({bus_req_valid, bus_req_addr} !== {1'b1, 64'h1008}) begin
      n_bad++; $display("FAIL mid_beat2 got %b/%h want 1/1008", bus_req_valid, bus_req_addr);
    end
    reset = 1'b1; mem_req_valid = 1'b0;
    pend.delete();
    step();
    pend.delete();
    n_cmp++;
    if ({mem_rsp_valid, bus_req_valid, bus_req_we, busy, bus_err} !== 5'b0) begin
      n_bad++; $display("FAIL mid_reset_ctrl got %b want 00000",
                        {mem_rsp_valid, bus_req_valid, bus_req_we, busy, bus_err});
    end
    n_cmp++;
    if ({mem_rsp_load_data, bus_req_addr, bus_req_wdata, bus_req_tag} !== 228'h0) begin
      n_bad++; $display("FAIL mid_reset_data got %h/%h/%h want 0", mem_rsp_load_data, bus_req_addr, bus_req_wdata);
    end
    reset = 1'b0; exp_load = '0;
    step();
    run_txn(MEM_LD_LINE, 64'h1000, '0, 4'h7, ta, tr);
    exp_load = ref_line(64'h1000);
    n_cmp++;
    if (tr - ta != 6) begin n_bad++; $display("FAIL post_reset_latency got %0d want 6", tr - ta); end
    n_cmp++;
    if (mem_rsp_load_data !== exp_load) begin
      n_bad++; $display("FAIL post_reset_data got %h want %h", mem_rsp_load_data, exp_load);
    end
  endtask

  task automatic test_back_to_back();
    int ta1, tr1, ta2, tr2;
    logic [127:0] wl;
    logic [63:0]  ea;
    wl = {$urandom, $urandom, $urandom, $urandom};
    blog.delete();
    run_txn(MEM_LD_LINE, 64'h4000, '0, 4'h2, ta1, tr1);
    exp_load = ref_line(64'h4000);
    run_txn(MEM_ST_LINE, 64'h5000, wl, 4'h9, ta2, tr2);
    ref_store(64'h5000, wl);
    n_cmp++;
    if (ta2 != tr1 + 1) begin n_bad++; $display("FAIL b2b_accept got %0d want %0d", ta2, tr1 + 1); end
    n_cmp++;
    if (blog.size() != 8) begin n_bad++; $display("FAIL b2b_beats got %0d want 8", blog.size()); end
    for (int i = 0; i < blog.size() && i < 8; i++) begin
      ea = (i < 4) ? 64'h4000 + 64'(4 * i) : 64'h5000 + 64'(4 * (i - 4));
      n_cmp++;
      if ({blog[i].addr, blog[i].we} !== {ea, (i >= 4)} ||
          (i >= 4 && blog[i].wd !== wl[32*(i-4) +: 32])) begin
        n_bad++; $display("FAIL b2b_beat%0d got %h/%b/%h want %h", i, blog[i].addr, blog[i].we, blog[i].wd, ea);
      end
    end
    n_cmp++;
    if (tr2 < 0 || mem_rsp_load_data !== exp_load) begin
      n_bad++; $display("FAIL b2b_load got %h want %h (rsp %0d)", mem_rsp_load_data, exp_load, tr2);
    end
  endtask

  task automatic test_random();
    int ta, tr, nb, sel;
    logic [3:0]   op;
    logic [63:0]  a;
    logic [127:0] wl;
    rnd_rdy = 1; rnd_lat = 1;
    for (int k = 0; k < 24; k++) begin
      sel = int'($urandom_range(0, 9));
      op  = (sel < 4) ? MEM_LD_LINE : (sel < 9) ? MEM_ST_LINE : 4'd2;
      a   = 64'h8000 + 64'($urandom_range(0, 7)) * 64'd16 + 64'($urandom_range(0, 15));
      wl  = {$urandom, $urandom, $urandom, $urandom};
      blog.delete();
      run_txn(op, a, wl, 4'(k), ta, tr);
      nb = (op == MEM_LD_LINE || op == MEM_ST_LINE) ? 4 : 0;
      if (op == MEM_ST_LINE) ref_store(a, wl);
      if (op == MEM_LD_LINE) exp_load = ref_line(a);
      n_cmp++;
      if (tr < 0 || blog.size() != nb) begin
        n_bad++; $display("FAIL rnd%0d_beats got %0d want %0d (rsp %0d)", k, blog.size(), nb, tr);
      end
      for (int i = 0; i < blog.size() && i < nb; i++) begin
        n_cmp++;
        if ({blog[i].addr, blog[i].we, blog[i].tag} !== {align(a) + 64'(4 * i), (op == MEM_ST_LINE), 4'(k)} ||
            (op == MEM_ST_LINE && blog[i].wd !== wl[32*i +: 32])) begin
          n_bad++; $display("FAIL rnd%0d_beat%0d got %h/%b/%h want %h", k, i, blog[i].addr,
                            blog[i].we, blog[i].wd, align(a) + 64'(4 * i));
        end
      end
      n_cmp++;
      if (mem_rsp_load_data !== exp_load) begin
        n_bad++; $display("FAIL rnd%0d_load got %h want %h", k, mem_rsp_load_data, exp_load);
      end
    end
    rnd_rdy = 0; rnd_lat = 0;
  endtask

  initial begin
    reset = 1'b1; mem_req_valid = 1'b0; mem_req_addr = '0; mem_req_store_data = '0;
    mem_req_tag = '0; mem_req_opcode = '0; bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
    @(negedge clk);
    test_reset();
    test_read_basic();
    test_write_stall();
    test_delayed_rsp();
    test_stray_and_opcode();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
